// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared load/store type codes and MEM/WB FSM state encodings
package mem_wb_stage_pkg;
  typedef enum logic [2:0] {
    LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b011, LHU = 3'b100, LD_DEF = 3'b111
  } load_type_e;
  typedef enum logic [1:0] {
    SB = 2'b00, SH = 2'b01, SW = 2'b10, ST_DEF = 2'b11
  } store_type_e;
  typedef enum logic [1:0] {
    IDLE = 2'b00, REQ = 2'b01, WB = 2'b10
  } state_e;
endpackage

// File: rtl/mem_wb_stage_load_data_align.sv
// load_data_align: extracts the addressed byte/half of a read word and sign/zero-extends it
//   rdata     in  32  raw read word
//   offset    in  2   byte offset within the word
//   load_type in  3   load type code
//   data      out 32  formatted load value
module load_data_align
  import mem_wb_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{offset, 3'b000} +: 8];
    h = offset[1] ? rdata[31:16] : rdata[15:0];
    data = load_type == LB  ? {{24{b[7]}}, b} :
           load_type == LBU ? {24'b0, b} :
           load_type == LH  ? {{16{h[15]}}, h} :
           load_type == LHU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory access + writeback stage with IDLE/REQ/WB handshake FSM
//   clk, rst (async active-low)
//   ex_*            in   EX result and control, accepted when ex_valid && ex_ready
//   ex_ready        out  high only in IDLE
//   dmem_*          out/in  data memory request/response
//   reg_file_wr_*   out  register-file write port (one-cycle pulse)
//   misaligned_exc, bus_err  out  one-cycle error pulses
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_write,
  input  logic        ex_wb_load,
  input  logic        ex_wb_reg_file,
  input  logic [2:0]  ex_mem_load_type,
  input  logic [1:0]  ex_mem_store_type,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        reg_file_wr_en,
  output logic [4:0]  reg_file_wr_addr,
  output logic [31:0] reg_file_wr_data,
  output logic        misaligned_exc,
  output logic        bus_err
);
  localparam int CW = $clog2(ACK_TIMEOUT) + 1;
  state_e        state;
  logic [CW-1:0] cnt;
  logic [1:0]    off_q;
  logic [4:0]    rd_q;
  logic [2:0]    lt_q;
  logic          load_q, wbrf_q;
  logic          is_store, is_load, mis;
  logic [31:0]   wdata_c, load_data;
  logic [3:0]    wstrb_c;
  assign ex_ready = state == IDLE;
  always_comb begin
    is_store = ex_mem_write && ex_mem_store_type != ST_DEF;
    is_load  = !is_store && ex_wb_load && ex_mem_load_type != LD_DEF;
    mis = is_store ? (ex_mem_store_type == SH && ex_alu_result[0]) ||
                     (ex_mem_store_type == SW && ex_alu_result[1:0] != 2'b00) :
          is_load  ? ((ex_mem_load_type == LH || ex_mem_load_type == LHU) && ex_alu_result[0]) ||
                     (ex_mem_load_type == LW && ex_alu_result[1:0] != 2'b00) : 1'b0;
    wdata_c = ex_mem_store_type == SB ? {4{ex_store_data[7:0]}} :
              ex_mem_store_type == SH ? {2{ex_store_data[15:0]}} : ex_store_data;
    wstrb_c = ex_mem_store_type == SB ? 4'b0001 << ex_alu_result[1:0] :
              ex_mem_store_type == SH ? (ex_alu_result[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  end
  load_data_align u_align (
    .rdata     (dmem_rdata),
    .offset    (off_q),
    .load_type (lt_q),
    .data      (load_data)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      cnt              <= '0;
      off_q            <= '0;
      rd_q             <= '0;
      lt_q             <= '0;
      load_q           <= 1'b0;
      wbrf_q           <= 1'b0;
      dmem_req         <= 1'b0;
      dmem_we          <= 1'b0;
      dmem_addr        <= '0;
      dmem_wdata       <= '0;
      dmem_wstrb       <= '0;
      reg_file_wr_en   <= 1'b0;
      reg_file_wr_addr <= '0;
      reg_file_wr_data <= '0;
      misaligned_exc   <= 1'b0;
      bus_err          <= 1'b0;
    end else begin
      reg_file_wr_en   <= 1'b0;
      reg_file_wr_addr <= '0;
      reg_file_wr_data <= '0;
      misaligned_exc   <= 1'b0;
      bus_err          <= 1'b0;
      case (state)
        IDLE: if (ex_valid) begin
          off_q  <= ex_alu_result[1:0];
          rd_q   <= ex_rd;
          lt_q   <= ex_mem_load_type;
          load_q <= is_load;
          wbrf_q <= ex_wb_reg_file;
          if (mis) misaligned_exc <= 1'b1;
          else if (is_store || is_load) begin
            state      <= REQ;
            cnt        <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {ex_alu_result[31:2], 2'b00};
            dmem_wdata <= is_store ? wdata_c : 32'h0;
            dmem_wstrb <= is_store ? wstrb_c : 4'h0;
          end else begin
            state            <= WB;
            reg_file_wr_en   <= ex_wb_reg_file && ex_rd != 5'd0;
            reg_file_wr_addr <= ex_rd;
            reg_file_wr_data <= ex_alu_result;
          end
        end
        REQ: if (dmem_ack) begin
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          state    <= load_q ? WB : IDLE;
          if (load_q) begin
            reg_file_wr_en   <= wbrf_q && rd_q != 5'd0;
            reg_file_wr_addr <= rd_q;
            reg_file_wr_data <= load_data;
          end
        end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
          // timeout: abandon the op without a write
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          bus_err  <= 1'b1;
          state    <= IDLE;
        end else cnt <= cnt + CW'(1);
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_store_data = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_mem_write = 1'b0;
  logic        ex_wb_load = 1'b0;
  logic        ex_wb_reg_file = 1'b0;
  logic [2:0]  ex_mem_load_type = 3'b111;
  logic [1:0]  ex_mem_store_type = 2'b11;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        reg_file_wr_en;
  logic [4:0]  reg_file_wr_addr;
  logic [31:0] reg_file_wr_data;
  logic        misaligned_exc, bus_err;
  int tests = 0;
  int fails = 0;
  mem_wb_stage #(.ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_mem_write(ex_mem_write), .ex_wb_load(ex_wb_load), .ex_wb_reg_file(ex_wb_reg_file),
    .ex_mem_load_type(ex_mem_load_type), .ex_mem_store_type(ex_mem_store_type),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .reg_file_wr_en(reg_file_wr_en), .reg_file_wr_addr(reg_file_wr_addr),
    .reg_file_wr_data(reg_file_wr_data), .misaligned_exc(misaligned_exc), .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                    input logic mw, input logic ld, input logic rf,
                    input logic [2:0] lt, input logic [1:0] st);
    ex_valid = 1'b1; ex_alu_result = alu; ex_store_data = sd; ex_rd = rd;
    ex_mem_write = mw; ex_wb_load = ld; ex_wb_reg_file = rf;
    ex_mem_load_type = lt; ex_mem_store_type = st;
  endtask
  initial begin
    cyc(); cyc();
    chk("rst_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_wr_en", {31'b0, reg_file_wr_en}, 32'd0);
    rst = 1'b1;
    cyc();
    chk("rst_ready", {31'b0, ex_ready}, 32'd1);
    // ADD x5
    op(32'h0000_1234, 0, 5'd5, 0, 0, 1, 3'b111, 2'b11);
    cyc();
    ex_valid = 1'b0;
    chk("add_wr_en", {31'b0, reg_file_wr_en}, 32'd1);
    chk("add_wr_addr", {27'b0, reg_file_wr_addr}, 32'd5);
    chk("add_wr_data", reg_file_wr_data, 32'h0000_1234);
    chk("add_ready_wb", {31'b0, ex_ready}, 32'd0);
    cyc();
    chk("add_wr_en_off", {31'b0, reg_file_wr_en}, 32'd0);
    chk("add_ready_back", {31'b0, ex_ready}, 32'd1);
    // LB at 0x103, ack after 3 waits
    op(32'h0000_0103, 0, 5'd7, 0, 1, 1, 3'b000, 2'b11);
    cyc();
    ex_valid = 1'b0;
    chk("lb_req", {31'b0, dmem_req}, 32'd1);
    chk("lb_addr", dmem_addr, 32'h0000_0100);
    chk("lb_we", {31'b0, dmem_we}, 32'd0);
    cyc(); cyc();
    chk("lb_req_wait", {31'b0, dmem_req}, 32'd1);
    chk("lb_no_early_wr", {31'b0, reg_file_wr_en}, 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'h80FF_FFFF;
    cyc();
    dmem_ack = 1'b0;
    chk("lb_wr_en", {31'b0, reg_file_wr_en}, 32'd1);
    chk("lb_wr_addr", {27'b0, reg_file_wr_addr}, 32'd7);
    chk("lb_wr_data", reg_file_wr_data, 32'hFFFF_FF80);
    chk("lb_req_drop", {31'b0, dmem_req}, 32'd0);
    chk("lb_ready_m1", {31'b0, ex_ready}, 32'd0);
    cyc();
    chk("lb_ready_m2", {31'b0, ex_ready}, 32'd1);
    chk("lb_wr_pulse", {31'b0, reg_file_wr_en}, 32'd0);
    // LBU same data
    op(32'h0000_0103, 0, 5'd8, 0, 1, 1, 3'b011, 2'b11);
    cyc();
    ex_valid = 1'b0;
    dmem_ack = 1'b1;
    cyc();
    dmem_ack = 1'b0;
    chk("lbu_wr_en", {31'b0, reg_file_wr_en}, 32'd1);
    chk("lbu_wr_data", reg_file_wr_data, 32'h0000_0080);
    cyc();
    // LH at 0x102 selects upper half, sign-extended
    op(32'h0000_0102, 0, 5'd9, 0, 1, 1, 3'b001, 2'b11);
    cyc();
    ex_valid = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'h8001_1234;
    cyc();
    dmem_ack = 1'b0;
    chk("lh_wr_data", reg_file_wr_data, 32'hFFFF_8001);
    cyc();
    // SH at 0x202
    op(32'h0000_0202, 32'h0000_ABCD, 5'd3, 1, 0, 0, 3'b111, 2'b01);
    cyc();
    ex_valid = 1'b0;
    chk("sh_req", {31'b0, dmem_req}, 32'd1);
    chk("sh_we", {31'b0, dmem_we}, 32'd1);
    chk("sh_addr", dmem_addr, 32'h0000_0200);
    chk("sh_wstrb", {28'b0, dmem_wstrb}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    dmem_ack = 1'b1;
    cyc();
    dmem_ack = 1'b0;
    chk("sh_req_drop", {31'b0, dmem_req}, 32'd0);
    chk("sh_ready_m1", {31'b0, ex_ready}, 32'd1);
    chk("sh_no_wr", {31'b0, reg_file_wr_en}, 32'd0);
    // SB at 0x201
    op(32'h0000_0201, 32'h0000_0012, 5'd0, 1, 0, 0, 3'b111, 2'b00);
    cyc();
    ex_valid = 1'b0;
    chk("sb_wstrb", {28'b0, dmem_wstrb}, 32'h2);
    chk("sb_wdata", dmem_wdata, 32'h1212_1212);
    dmem_ack = 1'b1;
    cyc();
    dmem_ack = 1'b0;
    // misaligned LW
    op(32'h0000_0101, 0, 5'd4, 0, 1, 1, 3'b010, 2'b11);
    cyc();
    ex_valid = 1'b0;
    chk("mis_exc", {31'b0, misaligned_exc}, 32'd1);
    chk("mis_req", {31'b0, dmem_req}, 32'd0);
    chk("mis_no_wr", {31'b0, reg_file_wr_en}, 32'd0);
    chk("mis_ready", {31'b0, ex_ready}, 32'd1);
    cyc();
    chk("mis_pulse", {31'b0, misaligned_exc}, 32'd0);
    // LW with no ack: timeout after 16 cycles in REQ
    op(32'h0000_0300, 0, 5'd6, 0, 1, 1, 3'b010, 2'b11);
    cyc();
    ex_valid = 1'b0;
    for (int i = 0; i < 15; i++) cyc();
    chk("to_req_held", {31'b0, dmem_req}, 32'd1);
    chk("to_no_early_err", {31'b0, bus_err}, 32'd0);
    cyc();
    chk("to_bus_err", {31'b0, bus_err}, 32'd1);
    chk("to_req_drop", {31'b0, dmem_req}, 32'd0);
    chk("to_no_wr", {31'b0, reg_file_wr_en}, 32'd0);
    cyc();
    chk("to_err_pulse", {31'b0, bus_err}, 32'd0);
    chk("to_ready", {31'b0, ex_ready}, 32'd1);
    // stray ack while idle
    dmem_ack = 1'b1;
    cyc();
    dmem_ack = 1'b0;
    chk("stray_ack_no_wr", {31'b0, reg_file_wr_en}, 32'd0);
    chk("stray_ack_ready", {31'b0, ex_ready}, 32'd1);
    // reset mid-REQ
    op(32'h0000_0400, 0, 5'd10, 0, 1, 1, 3'b010, 2'b11);
    cyc();
    ex_valid = 1'b0;
    cyc();
    chk("rr_req_before", {31'b0, dmem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rr_req_async", {31'b0, dmem_req}, 32'd0);
    cyc();
    rst = 1'b1;
    dmem_ack = 1'b1;
    cyc();
    dmem_ack = 1'b0;
    chk("rr_ready", {31'b0, ex_ready}, 32'd1);
    chk("rr_no_wr", {31'b0, reg_file_wr_en}, 32'd0);
    cyc();
    chk("rr_no_wr_late", {31'b0, reg_file_wr_en}, 32'd0);
    // ADD with rd=0
    op(32'h0000_5555, 0, 5'd0, 0, 0, 1, 3'b111, 2'b11);
    cyc();
    ex_valid = 1'b0;
    chk("rd0_no_wr", {31'b0, reg_file_wr_en}, 32'd0);
    cyc();
    chk("rd0_no_wr_late", {31'b0, reg_file_wr_en}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
